candy_if: RTL and testbench
===========================

Name: candy_if

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the PC and issues word-addressed requests to instruction memory over a req/ack handshake. Fetched 24-bit instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake; inst_valid drives decode's id_enable. A redirect from execute (branch/jump) flushes the FIFO and restarts fetch at a new PC.

Parameters:
INST_W, 24, instruction width (type field in bits [23:22])
ADDR_W, 16, instruction-memory word address width
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, instruction FIFO entries; must be a power of 2 and at least 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
imem_req  out  1  fetch request; held until imem_ack
imem_addr  out  ADDR_W  word address of the request; stable while imem_req=1
imem_ack  in  1  memory accepts and returns data; meaningful only while imem_req=1
imem_rdata  in  INST_W  instruction word; valid when imem_ack=1
inst_valid  out  1  FIFO head valid; goes to decode id_enable
inst  out  INST_W  FIFO head instruction
inst_pc  out  ADDR_W  address of the FIFO head instruction
inst_ready  in  1  decode consumes the head this cycle when inst_valid=1
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch address

Behaviour:
- Reset, synchronous: pc=RESET_PC, FIFO empty (count=0, pointers=0), imem_req=0, imem_addr=RESET_PC, state=FETCH, inst_valid=0. inst and inst_pc read the head storage and are don't-care while inst_valid=0.
- Single outstanding request only. Memory may assert ack in the same cycle as req or in any later cycle. A transaction completes on a clock edge where imem_req=1 and imem_ack=1.
- Credit rule: a new request may start only when count + (completing enqueue ? 1 : 0) - (dequeue ? 1 : 0) < DEPTH. This guarantees an ack never finds the FIFO full.
- States:
  - FETCH: no outstanding request. If credit is available and there is no redirect, assert imem_req with imem_addr=pc on the next edge and go to WAIT.
  - WAIT: imem_req=1. On ack with no redirect, enqueue {imem_rdata, imem_addr}, set pc=pc+1, and deassert req, or keep req asserted with addr=pc+1 if credit allows (back-to-back fetch, one instruction per cycle sustained with zero-latency ack).
  - DROP: a redirect arrived while a request was pending. Keep req and addr unchanged until ack. Discard the returned data and do not enqueue. Then go to FETCH with pc already equal to redirect_pc.
- PC arithmetic: pc+1 wraps modulo 2^ADDR_W without any flag.
- Decode handshake: a dequeue happens when inst_valid and inst_ready. inst and inst_pc come from registered FIFO storage, with no combinational path from imem_rdata. First instruction latency: the enqueue edge, then inst_valid=1 in the following cycle.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged.
- Redirect, highest priority:
  - Any enqueue or dequeue in that cycle is cancelled.
  - FIFO is flushed to empty and pc=redirect_pc.
  - In FETCH, or in WAIT with ack in the same cycle: next state is FETCH and the acked data is discarded.
  - In WAIT without ack: next state is DROP.
  - In DROP: update pc only and stay in DROP.
  - inst_valid is 0 in the cycle after the redirect.
- Back-to-back redirects: the last one wins.
- Reset mid-transaction: the pending request is abandoned. The memory system is reset on the same rst.

Test Plan:
- Reset then run with ack tied to 1 and inst_ready=1, imem_rdata=addr+0x100000 -> addresses 0,1,2,3... on consecutive cycles; inst_valid high from cycle 2; inst_pc sequence 0,1,2; inst=0x100000,0x100001...
- Ack latency of 3 cycles -> imem_addr held stable for 4 cycles per fetch; one instruction every 4 cycles; no duplicated or skipped PCs.
- inst_ready=0 with DEPTH=2 -> exactly 2 fetches, then imem_req stays 0; release ready -> head 0 then 1 delivered, fetch resumes at PC 2.
- Redirect to 0x0040 while in WAIT, ack arriving 2 cycles later -> returned word is dropped; next request addr=0x0040; first inst_pc after the redirect is 0x0040.
- Redirect to 0x0010 in the same cycle as an ack and a dequeue -> acked data is not enqueued; inst_valid=0 next cycle; next imem_addr=0x0010.
- PC at 0xFFFF with ack=1 -> next fetch address is 0x0000. Reset asserted in WAIT -> next cycle imem_req=0 and inst_valid=0, and the first request after reset uses RESET_PC.

Source files
------------

// File: rtl/candy_if.sv
// rtl/candy_if.sv - instruction fetch stage with PC, imem req/ack port and instruction FIFO
//
// Owns the fetch PC, issues one word-addressed request at a time to instruction
// memory and buffers returned instructions in a DEPTH-entry FIFO for decode.
// A redirect from execute flushes the FIFO and restarts fetch at redirect_pc.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req/addr     fetch request, held with a stable address until imem_ack
//   imem_ack/rdata    memory completion and returned instruction word
//   inst_valid        FIFO head valid (drives decode id_enable)
//   inst, inst_pc     FIFO head instruction and its word address
//   inst_ready        decode consumes the head this cycle
//   redirect_valid/pc flush and restart fetch at redirect_pc
module candy_if #(
  parameter int unsigned INST_W   = 24,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_DROP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] pc_inc;
  logic              req_nx;
  logic [ADDR_W-1:0] addr_nx;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];

  logic              done;
  logic              enq;
  logic              deq;
  logic [CNT_W:0]    occ_after;
  logic              credit;

  assign done       = imem_req && imem_ack;
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  // While a request is outstanding in WAIT, pc always equals imem_addr.
  assign pc_inc     = pc + ADDR_W'(1);

  always_comb begin
    enq       = (state == S_WAIT) && done && !redirect_valid;
    deq       = inst_valid && inst_ready && !redirect_valid;
    // Occupancy after this edge; a new request is only launched if its
    // data is guaranteed a free slot when it returns.
    occ_after = {1'b0, count} + (CNT_W + 1)'(enq) - (CNT_W + 1)'(deq);
    credit    = (occ_after < (CNT_W + 1)'(DEPTH));

    state_nx  = state;
    pc_nx     = pc;
    req_nx    = imem_req;
    addr_nx   = imem_addr;

    case (state)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
        end else if (credit) begin
          req_nx   = 1'b1;
          addr_nx  = pc;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
          if (done) begin
            req_nx   = 1'b0;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_DROP;
          end
        end else if (done) begin
          pc_nx = pc_inc;
          if (credit) begin
            addr_nx = pc_inc;
          end else begin
            req_nx   = 1'b0;
            state_nx = S_FETCH;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
        end
        // The stale request completes even if another redirect lands on the
        // same edge; holding req beyond its ack would issue a phantom fetch.
        if (done) begin
          req_nx   = 1'b0;
          state_nx = S_FETCH;
        end
      end
      default: begin
        state_nx = S_FETCH;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= ADDR_W'(RESET_PC);
      imem_req  <= 1'b0;
      imem_addr <= ADDR_W'(RESET_PC);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Storage needs no reset: inst/inst_pc are ignored while inst_valid=0.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= imem_addr;
    end
  end

endmodule

// File: tb/tb_candy_if.sv
// tb/tb_candy_if.sv - scoreboard testbench for candy_if
module tb_candy_if;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [23:0] imem_rdata;
  logic        inst_valid;
  logic [23:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  candy_if #(
    .INST_W  (24),
    .ADDR_W  (16),
    .RESET_PC(0),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  // Memory returns 0x100000 + address for every word.
  assign imem_rdata = {8'h10, imem_addr};

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_fetch[$];
  logic [39:0] exp_inst[$];
  int          fetch_cnt;

  logic        mem_auto;
  logic        man_ack;
  int          mem_lat;
  int          mem_budget;
  int          mem_age;
  logic        mem_pend;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_fetch.push_back(a);
      exp_inst.push_back({a, 8'h10, a});
      a = a + 16'd1;
    end
  endtask

  // Memory model: acks after mem_lat extra cycles, at most mem_budget times.
  task automatic model_loop();
    forever begin
      @(negedge clk);
      #1;
      if (!mem_auto) begin
        imem_ack = man_ack;
        mem_pend = 1'b0;
        mem_age  = 0;
      end else begin
        if (imem_req && mem_pend) mem_age++;
        else mem_age = 0;
        imem_ack = imem_req && (mem_age >= mem_lat) && (mem_budget > 0);
        if (imem_ack) mem_budget--;
        mem_pend = imem_req && !imem_ack;
      end
    end
  endtask

  task automatic monitor_loop();
    logic        prev_pend;
    logic [15:0] prev_addr;
    logic [39:0] e;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        fetch_cnt = 0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) chk("addr_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
        if (imem_req && imem_ack) begin
          fetch_cnt++;
          if (exp_fetch.size() == 0) begin
            chk("unexpected_fetch", {1'b1, imem_addr}, 64'd0);
          end else begin
            chk("fetch_addr", imem_addr, exp_fetch.pop_front());
          end
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
          if (exp_inst.size() == 0) begin
            chk("unexpected_inst", {1'b1, inst_pc, inst}, 64'd0);
          end else begin
            e = exp_inst.pop_front();
            chk("inst_pc_data", {inst_pc, inst}, e);
          end
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  endtask

  task automatic do_reset(input logic auto_m, input int lat, input int budget, input logic ready);
    rst            = 1'b1;
    mem_auto       = 1'b0;
    man_ack        = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    mem_auto   = auto_m;
    mem_lat    = lat;
    mem_budget = budget;
    inst_ready = ready;
    rst        = 1'b0;
  endtask

  task automatic end_test(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_fetch.size() == 0 && exp_inst.size() == 0) break;
      tick();
    end
    chk(name, exp_fetch.size() + exp_inst.size(), 64'd0);
    exp_fetch.delete();
    exp_inst.delete();
  endtask

  initial begin
    n_checks = 0; n_errors = 0; fetch_cnt = 0;
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_auto = 1'b0; man_ack = 1'b0; imem_ack = 1'b0;
    mem_lat = 0; mem_budget = 0; mem_age = 0; mem_pend = 1'b0;
    fork
      model_loop();
      monitor_loop();
    join_none

    // Reset state
    tick(); tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);

    // Zero-latency ack, continuous streaming
    push_seq(16'h0000, 8);
    do_reset(1'b1, 0, 8, 1'b1);
    tick();
    chk("t1_c1", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0000, 1'b0});
    tick();
    chk("t1_c2", {imem_addr, inst_valid, inst_pc, inst}, {16'h0001, 1'b1, 16'h0000, 24'h100000});
    tick();
    chk("t1_c3", {imem_addr, inst_valid, inst_pc}, {16'h0002, 1'b1, 16'h0001});
    end_test("t1_drain", 30);

    // Ack latency 3: one instruction every 4 cycles
    push_seq(16'h0000, 3);
    do_reset(1'b1, 3, 3, 1'b1);
    repeat (4) tick();
    chk("t2_c4", {imem_req, imem_addr}, {1'b1, 16'h0000});
    tick();
    chk("t2_c5", {imem_req, imem_addr, inst_valid, inst_pc}, {1'b1, 16'h0001, 1'b1, 16'h0000});
    end_test("t2_drain", 40);

    // Decode stalled: exactly DEPTH fetches, then resume at PC 2
    push_seq(16'h0000, 10);
    do_reset(1'b1, 0, 10, 1'b0);
    repeat (6) tick();
    chk("t3_stall", {imem_req, inst_valid, inst_pc}, {1'b0, 1'b1, 16'h0000});
    chk("t3_fetch_cnt", fetch_cnt, 2);
    inst_ready = 1'b1;
    tick();
    chk("t3_resume", {imem_req, imem_addr, inst_pc}, {1'b1, 16'h0002, 16'h0001});
    end_test("t3_drain", 40);

    // Redirect while waiting; stale word returns 2 cycles later and is dropped
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0040);
    exp_inst.push_back({16'h0040, 24'h100040});
    do_reset(1'b0, 0, 0, 1'b1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    chk("t4_drop_hold", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0000, 1'b0});
    tick();
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t4_after_drop", {imem_req, inst_valid}, {1'b0, 1'b0});
    tick();
    chk("t4_new_req", {imem_req, imem_addr}, {1'b1, 16'h0040});
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    chk("t4_first_inst", {inst_valid, inst_pc}, {1'b1, 16'h0040});
    end_test("t4_drain", 10);

    // Redirect coinciding with ack and dequeue
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0001);
    exp_fetch.push_back(16'h0010);
    exp_inst.push_back({16'h0010, 24'h100010});
    do_reset(1'b0, 0, 0, 1'b1);
    tick();
    man_ack = 1'b1;
    tick();
    chk("t5_pre", {inst_valid, inst_pc, imem_addr}, {1'b1, 16'h0000, 16'h0001});
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0; man_ack = 1'b0;
    chk("t5_flushed", {inst_valid, imem_req}, {1'b0, 1'b0});
    tick();
    chk("t5_new_req", {imem_req, imem_addr}, {1'b1, 16'h0010});
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    end_test("t5_drain", 10);

    // PC wrap at 0xFFFF
    push_seq(16'hFFFF, 3);
    do_reset(1'b1, 0, 3, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("t6_fetch_redirect", imem_req, 1'b0);
    tick();
    chk("t6_req_ffff", {imem_req, imem_addr}, {1'b1, 16'hFFFF});
    tick();
    chk("t6_wrap", {imem_req, imem_addr}, {1'b1, 16'h0000});
    end_test("t6_drain", 20);

    // Reset while waiting abandons the request; restart at RESET_PC
    push_seq(16'h0000, 1);
    do_reset(1'b1, 8, 1, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'h0123;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t7_wait", {imem_req, imem_addr}, {1'b1, 16'h0123});
    tick();
    rst = 1'b1;
    tick();
    chk("t7_in_reset", {imem_req, inst_valid}, {1'b0, 1'b0});
    rst = 1'b0;
    tick();
    chk("t7_restart", {imem_req, imem_addr}, {1'b1, 16'h0000});
    end_test("t7_drain", 40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
